stack_cmd_driver: RTL and testbench
===================================

Name: stack_cmd_driver

Overview:
- Upstream sequencer for the 5-entry, 4-bit circular stack.
- Accepts host requests over a valid/ready handshake and tracks occupancy so the stack is never over- or under-run.
- Issues exactly one-cycle COMMAND pulses, drives or tri-states the shared 4-bit data bus, captures read data, and returns a response with an error flag.

Parameters:
- DEPTH, 5, stack entries; must equal the stack's depth.
- DW, 4, data width; must equal the stack's bus width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset. Also wired to the stack's RESET.
- REQ_VALID  in  1  host request valid.
- REQ_READY  out  1  driver can accept a request.
- REQ_OP  in  2  01 push, 10 pop, 11 get, 00 illegal.
- REQ_INDEX  in  3  get depth; 0 = top of stack.
- REQ_DATA  in  DW  push data.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  host accepts response.
- RSP_DATA  out  DW  push: echoed value; pop/get: read value; error: 0.
- RSP_ERR  out  1  request rejected, no stack command issued.
- COUNT  out  3  current occupancy, 0..DEPTH.
- STK_COMMAND  out  2  to stack COMMAND.
- STK_INDEX  out  3  to stack INDEX.
- STK_DATA  inout  DW  shared stack data bus.

Behaviour:
- All state updates on posedge CLK except the capture register, which updates on negedge CLK.
- Reset (RESET=1 at posedge):
  - state=IDLE, COUNT=0, STK_COMMAND=00, STK_INDEX=0, STK_DATA released (Z).
  - REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0.
  - Reset mid-operation aborts with no response. Any COMMAND already registered is cleared at that edge.
- FSM states: IDLE, ISSUE, EXEC, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch op, index and data, then run the legality check:
    - Push requires COUNT<DEPTH.
    - Pop requires COUNT>0.
    - Get requires REQ_INDEX<COUNT.
    - op 00 is always illegal.
  - Legal request: STK_COMMAND<=op, STK_INDEX<=index, go to ISSUE.
  - Illegal request: RSP_ERR<=1, RSP_DATA<=0, go to RESP. No stack command is ever issued.
- ISSUE (one cycle):
  - STK_COMMAND holds the op.
  - For push, STK_DATA is driven with the latched data for the whole cycle, so the stack samples it at the next posedge.
  - At the end of the cycle: STK_COMMAND<=00, go to EXEC.
- EXEC (one cycle):
  - The stack executed the command at the edge entering EXEC.
  - For pop/get, the stack drives STK_DATA during the high phase of this cycle only. The capture register samples STK_DATA at this cycle's falling edge.
  - At the end of the cycle, update COUNT: push +1, pop -1, get unchanged. RSP_ERR<=0.
  - RSP_DATA<=capture register for pop/get, or latched data for push. Go to RESP.
- RESP:
  - RSP_VALID=1 with RSP_DATA and RSP_ERR held stable.
  - On RSP_READY, go to IDLE.
  - REQ_READY=0 throughout.
- Bus ownership: the driver drives STK_DATA only in ISSUE for a push. STK_DATA is Z in every other state and never driven while STK_COMMAND is 10 or 11.
- STK_COMMAND is non-00 for exactly one CLK period per legal request, and 00 at all other times.
- Latency, no backpressure:
  - Legal request accepted at edge k gives RSP_VALID high from edge k+3.
  - Illegal request gives RSP_VALID high from edge k+1.
- Throughput: one request in flight. The next request is accepted only in IDLE, so back-to-back requests are 4 cycles apart when RSP_READY is held 1.
- REQ_INDEX 5..7 always fails the legality check, since COUNT≤5.
- COUNT never wraps.

Optional Feature:
- Macro: STACK_DRV_OVERWRITE_EN.
- Defined:
  - Push with COUNT==DEPTH is legal and issued; the stack overwrites its oldest entry.
  - COUNT stays DEPTH, RSP_ERR=0.
- Undefined: push on full gives RSP_ERR=1 and no command.

Test Plan:
- Reset, then push 4'h3, 4'hA, 4'h5 -> each response err=0 and echoes its data. COUNT=3. STK_COMMAND=01 for exactly one cycle per push.
- Get index 0, 1, 2 -> RSP_DATA 5, A, 3. COUNT stays 3. STK_DATA is Z from the driver during every get.
- Pop three times -> 5, A, 3. COUNT=0. A fourth pop -> err=1, data=0, STK_COMMAND stays 00.
- Push 1..5, then push 6 -> err=1 with macro undefined. With STACK_DRV_OVERWRITE_EN defined -> err=0, COUNT=5, and get index 0 returns 6.
- Push 7 with RSP_READY held 0 for 5 cycles -> RSP_VALID and RSP_DATA=7 held stable. REQ_READY=0 until the handshake completes.
- Assert RESET during EXEC of a pop -> no response. COUNT=0, bus Z. The next get index 0 returns err=1.

Source files
------------

// File: rtl/stack_cmd_driver.sv
// stack_cmd_driver
//   Upstream sequencer for a DEPTH-entry, DW-bit circular stack. Accepts one
//   host request at a time, checks it against the tracked occupancy, issues a
//   single-cycle COMMAND pulse to the stack, owns the shared data bus only while
//   presenting push data, captures read data on the falling edge of EXEC and
//   returns a response carrying the data and an error flag.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset (shared with stack)
//   REQ_VALID/READY     host request handshake
//   REQ_OP              01 push, 10 pop, 11 get, 00 illegal
//   REQ_INDEX           get depth, 0 = top of stack
//   REQ_DATA            push data
//   RSP_VALID/READY     response handshake
//   RSP_DATA            push echo, pop/get read value, 0 on error
//   RSP_ERR             request rejected, no stack command issued
//   COUNT               current occupancy 0..DEPTH
//   STK_COMMAND         to stack COMMAND
//   STK_INDEX           to stack INDEX
//   STK_DATA            shared bidirectional stack data bus
//
// Build option
//   STACK_DRV_OVERWRITE_EN  when defined, a push on a full stack is issued
//                           (the stack overwrites its oldest entry) and COUNT
//                           saturates at DEPTH; otherwise it is rejected.

module stack_cmd_driver #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned DW    = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [1:0]    REQ_OP,
  input  logic [2:0]    REQ_INDEX,
  input  logic [DW-1:0] REQ_DATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_DATA,
  output logic          RSP_ERR,
  output logic [2:0]    COUNT,
  output logic [1:0]    STK_COMMAND,
  output logic [2:0]    STK_INDEX,
  inout  logic [DW-1:0] STK_DATA
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_GET  = 2'b11
  } op_e;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  op_e           cmd_q, cmd_d;
  op_e           req_op;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [2:0]    count_q, count_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] cap_q;
  logic          push_ok;
  logic          legal;
  logic          bus_drive;

  assign req_op = op_e'(REQ_OP);

`ifdef STACK_DRV_OVERWRITE_EN
  assign push_ok = 1'b1;
`else
  assign push_ok = (count_q < DEPTH_C);
`endif

  always_comb begin
    legal = 1'b0;
    case (req_op)
      OP_PUSH: legal = push_ok;
      OP_POP:  legal = (count_q != '0);
      OP_GET:  legal = (REQ_INDEX < count_q);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    data_d     = data_q;
    count_d    = count_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          op_d   = req_op;
          idx_d  = REQ_INDEX;
          data_d = REQ_DATA;
          if (legal) begin
            cmd_d   = req_op;
            state_d = ISSUE;
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RESP;
          end
        end
      end

      ISSUE: begin
        cmd_d   = OP_NONE;
        state_d = EXEC;
      end

      EXEC: begin
        case (op_q)
          OP_PUSH: begin
            // Saturates only when overwrite-on-full pushes are allowed.
            if (count_q < DEPTH_C) begin
              count_d = count_q + 3'd1;
            end
          end
          OP_POP: begin
            if (count_q != '0) begin
              count_d = count_q - 3'd1;
            end
          end
          default: count_d = count_q;
        endcase
        rsp_err_d  = 1'b0;
        rsp_data_d = (op_q == OP_PUSH) ? data_q : cap_q;
        state_d    = RESP;
      end

      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      cmd_q      <= OP_NONE;
      idx_q      <= '0;
      data_q     <= '0;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      count_q    <= count_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // The stack drives read data only in the high phase of EXEC, so the
  // capture happens on the falling edge, half a cycle before the response
  // register takes it at the end of EXEC.
  always_ff @(negedge CLK) begin
    if (RESET) begin
      cap_q <= '0;
    end else if (state_q == EXEC) begin
      cap_q <= STK_DATA;
    end
  end

  assign bus_drive = (state_q == ISSUE) && (op_q == OP_PUSH);
  assign STK_DATA  = bus_drive ? data_q : 'z;

  // Ready is masked by RESET so the host never sees a grant while reset is held.
  assign REQ_READY   = (state_q == IDLE) && !RESET;
  assign RSP_VALID   = (state_q == RESP);
  assign RSP_DATA    = rsp_data_q;
  assign RSP_ERR     = rsp_err_q;
  assign COUNT       = count_q;
  assign STK_COMMAND = cmd_q;
  assign STK_INDEX   = idx_q;

  a_cmd_single_cycle: assert property (
    @(posedge CLK) disable iff (RESET) (cmd_q != OP_NONE) |=> (cmd_q == OP_NONE));

  a_count_bounded: assert property (
    @(posedge CLK) disable iff (RESET) (count_q <= DEPTH_C));

  a_no_drive_on_read: assert property (
    @(posedge CLK) disable iff (RESET)
      !(bus_drive && ((cmd_q == OP_POP) || (cmd_q == OP_GET))));

endmodule

// File: tb/tb_stack_cmd_driver.sv
module tb_stack_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_index;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [2:0] count;
  logic [1:0] stk_command;
  logic [2:0] stk_index;
  wire  [3:0] stk_data;

  int checks = 0;
  int passes = 0;
  int cmd_pulses = 0;
  int run_len = 0;

  typedef struct {
    logic       err;
    logic [3:0] data;
    string      name;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  stack_cmd_driver #(.DEPTH(5), .DW(4)) dut (
    .CLK(clk),
    .RESET(rst),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_OP(req_op),
    .REQ_INDEX(req_index),
    .REQ_DATA(req_data),
    .RSP_VALID(rsp_valid),
    .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data),
    .RSP_ERR(rsp_err),
    .COUNT(count),
    .STK_COMMAND(stk_command),
    .STK_INDEX(stk_index),
    .STK_DATA(stk_data)
  );

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Behavioural 5-entry circular stack; overwrites its oldest entry when full.
  logic [3:0] mem [5];
  int         top  = 0;
  int         scnt = 0;
  logic       drv_en = 1'b0;
  logic [3:0] drv_val = '0;

  assign stk_data = drv_en ? drv_val : 'z;

  always @(posedge clk) begin
    int t;
    if (rst) begin
      top    <= 0;
      scnt   <= 0;
      drv_en <= 1'b0;
    end else begin
      case (stk_command)
        2'b01: begin
          t = (top + 1) % 5;
          mem[t] <= stk_data;
          top    <= t;
          if (scnt < 5) scnt <= scnt + 1;
        end
        2'b10: begin
          drv_val <= mem[top];
          drv_en  <= 1'b1;
          top     <= (top + 4) % 5;
          if (scnt > 0) scnt <= scnt - 1;
        end
        2'b11: begin
          t = (top + 5 - int'(stk_index)) % 5;
          drv_val <= mem[t];
          drv_en  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) drv_en <= 1'b0;

  // While the stack drives the bus, it must carry the stack's value alone.
  always @(posedge clk) begin
    #2;
    if (drv_en) chk("bus_read_value", int'(stk_data), int'(drv_val));
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_response", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk({"rsp_err:", e.name}, int'(rsp_err), int'(e.err));
        chk({"rsp_data:", e.name}, int'(rsp_data), int'(e.data));
      end
    end
  end

  // Command pulse monitor: every non-00 run must last exactly one cycle.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (stk_command != 2'b00) begin
      run_len++;
      if (run_len == 1) cmd_pulses++;
    end else if (run_len != 0) begin
      chk("cmd_pulse_len", run_len, 1);
      run_len = 0;
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] d,
                      input logic exp_err, input logic [3:0] exp_d, input string nm);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({"req_ready_wait:", nm}, int'(req_ready), 1);
    sbq.push_back('{exp_err, exp_d, nm});
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk({"latency:", nm}, lat, exp_err ? 0 : 2);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({"rsp_handshake:", nm}, sbq.size(), 0);
    if (sbq.size() != 0) sbq.delete();
  endtask

  task automatic req(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] d,
                     input logic exp_err, input logic [3:0] exp_d, input string nm);
    int p0;
    p0 = cmd_pulses;
    send(op, idx, d, exp_err, exp_d, nm);
    drain(nm);
    chk({"cmd_pulses:", nm}, cmd_pulses - p0, exp_err ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_index = 3'd0;
    req_data  = 4'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_stk_command", int'(stk_command), 0);
    chk("reset_stk_index", int'(stk_index), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    req(2'b01, 3'd0, 4'h3, 1'b0, 4'h3, "push_3");
    req(2'b01, 3'd0, 4'hA, 1'b0, 4'hA, "push_A");
    req(2'b01, 3'd0, 4'h5, 1'b0, 4'h5, "push_5");
    chk("count_after_3_push", int'(count), 3);

    req(2'b11, 3'd0, 4'h0, 1'b0, 4'h5, "get_0");
    req(2'b11, 3'd1, 4'h0, 1'b0, 4'hA, "get_1");
    req(2'b11, 3'd2, 4'h0, 1'b0, 4'h3, "get_2");
    req(2'b11, 3'd3, 4'h0, 1'b1, 4'h0, "get_3_beyond_count");
    chk("count_after_gets", int'(count), 3);

    req(2'b10, 3'd0, 4'h0, 1'b0, 4'h5, "pop_1");
    req(2'b10, 3'd0, 4'h0, 1'b0, 4'hA, "pop_2");
    req(2'b10, 3'd0, 4'h0, 1'b0, 4'h3, "pop_3");
    chk("count_after_pops", int'(count), 0);
    req(2'b10, 3'd0, 4'h0, 1'b1, 4'h0, "pop_empty");
    chk("count_after_pop_empty", int'(count), 0);
    req(2'b00, 3'd0, 4'h9, 1'b1, 4'h0, "op_00_illegal");

    req(2'b01, 3'd0, 4'h1, 1'b0, 4'h1, "fill_1");
    req(2'b01, 3'd0, 4'h2, 1'b0, 4'h2, "fill_2");
    req(2'b01, 3'd0, 4'h3, 1'b0, 4'h3, "fill_3");
    req(2'b01, 3'd0, 4'h4, 1'b0, 4'h4, "fill_4");
    req(2'b01, 3'd0, 4'h5, 1'b0, 4'h5, "fill_5");
    chk("count_full", int'(count), 5);
`ifdef STACK_DRV_OVERWRITE_EN
    req(2'b01, 3'd0, 4'h6, 1'b0, 4'h6, "push_full_overwrite");
    chk("count_after_overwrite", int'(count), 5);
    req(2'b11, 3'd0, 4'h0, 1'b0, 4'h6, "get_0_after_overwrite");
    req(2'b10, 3'd0, 4'h0, 1'b0, 4'h6, "pop_after_full");
`else
    req(2'b01, 3'd0, 4'h6, 1'b1, 4'h0, "push_full_reject");
    chk("count_after_reject", int'(count), 5);
    req(2'b11, 3'd0, 4'h0, 1'b0, 4'h5, "get_0_after_reject");
    req(2'b10, 3'd0, 4'h0, 1'b0, 4'h5, "pop_after_full");
`endif
    req(2'b11, 3'd4, 4'h0, 1'b1, 4'h0, "get_4_count_4");
    req(2'b11, 3'd7, 4'h0, 1'b1, 4'h0, "get_7");
    chk("count_4", int'(count), 4);

    // Response backpressure: the response must hold while RSP_READY is low.
    rsp_ready = 1'b0;
    p0 = cmd_pulses;
    send(2'b01, 3'd0, 4'h7, 1'b0, 4'h7, "push_7_stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", int'(rsp_valid), 1);
      chk("stall_rsp_data", int'(rsp_data), 7);
      chk("stall_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    drain("push_7_stall");
    chk("cmd_pulses:push_7_stall", cmd_pulses - p0, 1);
    chk("count_after_stall", int'(count), 5);
    @(posedge clk); #1;
    chk("req_ready_after_stall", int'(req_ready), 1);

    // Reset asserted during EXEC of a pop: no response may appear.
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_index = 3'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midop_reset_count", int'(count), 0);
    chk("midop_reset_rsp_valid", int'(rsp_valid), 0);
    chk("midop_reset_stk_command", int'(stk_command), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    req(2'b11, 3'd0, 4'h0, 1'b1, 4'h0, "get_0_after_reset");
    req(2'b01, 3'd0, 4'h9, 1'b0, 4'h9, "push_9_after_reset");
    req(2'b11, 3'd0, 4'h0, 1'b0, 4'h9, "get_0_push_9");
    chk("count_final", int'(count), 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
